// File: rtl/mem_pkg.sv
// Shared types and helpers for the trainer scratch RAM (mem_ram).
// Holds the clear-sequencer state encoding and the even-parity helper.
package mem_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  // Widest data word the parity helper accepts; narrower words are zero-extended.
  localparam int PARITY_MAX_W = 64;

  function automatic logic even_parity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/mem_ram_if.sv
// Request/response bundle between the trainer control FSM and mem_ram.
// With MEM_RAM_PARITY_EN defined the bundle also carries parity_err.
interface mem_ram_if #(
  parameter int DATA_W = 2,
  parameter int ADDR_W = 4
) ();

  logic              we;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] d_in;
  logic              re;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] d_out;
  logic              d_valid;
  logic              busy;

`ifdef MEM_RAM_PARITY_EN
  logic              parity_err;

  modport master (
    output we, w_addr, d_in, re, r_addr,
    input  d_out, d_valid, busy, parity_err
  );

  modport slave (
    input  we, w_addr, d_in, re, r_addr,
    output d_out, d_valid, busy, parity_err
  );
`else
  modport master (
    output we, w_addr, d_in, re, r_addr,
    input  d_out, d_valid, busy
  );

  modport slave (
    input  we, w_addr, d_in, re, r_addr,
    output d_out, d_valid, busy
  );
`endif

endinterface

// File: rtl/mem_ram_array.sv
// Bare storage array: one write port, one registered read port, and an
// optional same-address bypass so a read can return the word being written.
module mem_ram_array #(
  parameter int WORD_W  = 2,
  parameter int ADDR_W  = 4,
  parameter int RDW_NEW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] w_addr,
  input  logic [WORD_W-1:0] w_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] r_addr,
  output logic [WORD_W-1:0] r_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [WORD_W-1:0] mem [DEPTH];
  logic              bypass;

  // Contents are deliberately left out of reset; the parent's clear sequence initialises them.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[w_addr] <= w_data;
    end
  end

  assign bypass = (RDW_NEW != 0) && we && (w_addr == r_addr);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (re) begin
      r_data <= bypass ? w_data : mem[r_addr];
    end
  end

endmodule

// File: rtl/mem_ram.sv
// Parametrised 1W/1R scratch RAM with a post-reset clear sequencer.
// Optional feature macro: MEM_RAM_PARITY_EN (per-word even parity + parity_err).
module mem_ram
  import mem_pkg::*;
#(
  parameter int DATA_W  = 2,
  parameter int ADDR_W  = 4,
  parameter int RDW_NEW = 0
) (
  input logic      clk,
  input logic      rst_n,
  mem_ram_if.slave bus
);

  localparam int DEPTH = 2 ** ADDR_W;
`ifdef MEM_RAM_PARITY_EN
  localparam int WORD_W = DATA_W + 1;
`else
  localparam int WORD_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(DEPTH - 1);

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W:0]   clr_idx;
  logic [ADDR_W:0]   clr_idx_nxt;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_waddr;
  logic [WORD_W-1:0] arr_wdata;
  logic [WORD_W-1:0] arr_rdata;
  logic [WORD_W-1:0] wr_word;
  logic              d_valid_q;

`ifdef MEM_RAM_PARITY_EN
  assign wr_word = {even_parity(PARITY_MAX_W'(bus.d_in)), bus.d_in};
`else
  assign wr_word = bus.d_in;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_nxt;
      clr_idx <= clr_idx_nxt;
    end
  end

  // The index is one bit wider than the address so it stops at DEPTH instead of wrapping.
  always_comb begin
    state_nxt   = state;
    clr_idx_nxt = clr_idx;
    arr_we      = 1'b0;
    arr_re      = 1'b0;
    arr_waddr   = bus.w_addr;
    arr_wdata   = wr_word;
    case (state)
      CLEAR: begin
        arr_we      = 1'b1;
        arr_waddr   = clr_idx[ADDR_W-1:0];
        arr_wdata   = '0;
        clr_idx_nxt = clr_idx + 1'b1;
        if (clr_idx == LAST_IDX) begin
          state_nxt = READY;
        end
      end
      READY: begin
        arr_we = bus.we;
        arr_re = bus.re;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_valid_q <= 1'b0;
    end else begin
      d_valid_q <= arr_re;
    end
  end

  mem_ram_array #(
    .WORD_W  (WORD_W),
    .ADDR_W  (ADDR_W),
    .RDW_NEW (RDW_NEW)
  ) u_array (
    .clk    (clk),
    .rst_n  (rst_n),
    .we     (arr_we),
    .w_addr (arr_waddr),
    .w_data (arr_wdata),
    .re     (arr_re),
    .r_addr (bus.r_addr),
    .r_data (arr_rdata)
  );

  assign bus.d_out   = arr_rdata[DATA_W-1:0];
  assign bus.d_valid = d_valid_q;
  assign bus.busy    = (state == CLEAR);

`ifdef MEM_RAM_PARITY_EN
  assign bus.parity_err = d_valid_q &
                          (arr_rdata[DATA_W] ^ even_parity(PARITY_MAX_W'(arr_rdata[DATA_W-1:0])));
`endif

endmodule
